// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT: FSM encoding, twiddle
// magnitudes (Q1.15 reference) and the round / saturate helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    STG1 = 2'd1,
    STG2 = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int TW_REF_FRAC = 15;
  localparam int TW_MAG0     = 32767;
  localparam int TW_MAG1     = 30274;
  localparam int TW_MAG2     = 23170;
  localparam int TW_MAG3     = 12540;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } tw_ref_t;

  // Forward W16^e = cos - j*sin in Q1.15; e = 0, 4, 8 are bypassed by the caller.
  function automatic tw_ref_t tw_lookup(input logic [3:0] e);
    tw_ref_t t;
    t.re = TW_MAG0;
    t.im = 0;
    case (e)
      4'd1: begin t.re =  TW_MAG1; t.im = -TW_MAG3; end
      4'd2: begin t.re =  TW_MAG2; t.im = -TW_MAG2; end
      4'd3: begin t.re =  TW_MAG3; t.im = -TW_MAG1; end
      4'd5: begin t.re = -TW_MAG3; t.im = -TW_MAG1; end
      4'd6: begin t.re = -TW_MAG2; t.im = -TW_MAG2; end
      4'd7: begin t.re = -TW_MAG1; t.im = -TW_MAG3; end
      4'd9: begin t.re = -TW_MAG1; t.im =  TW_MAG3; end
      default: ;
    endcase
    return t;
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/radix4_bfly.sv
// Combinational radix-4 butterfly with DW+2 bit growth; inverse swaps the
// roles of -j and +j.
module radix4_bfly
  import fft_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] a_re [4],
  input  logic signed [DW-1:0] a_im [4],
  input  logic                 inverse,
  output logic signed [DW+1:0] y_re [4],
  output logic signed [DW+1:0] y_im [4]
);

  localparam int SW = DW + 2;

  logic signed [SW-1:0] t0_re, t0_im, t1_re, t1_im;
  logic signed [SW-1:0] t2_re, t2_im, t3_re, t3_im;
  logic signed [SW-1:0] mj_re, mj_im, pj_re, pj_im;

  always_comb begin
    t0_re = SW'(a_re[0]) + SW'(a_re[2]);
    t0_im = SW'(a_im[0]) + SW'(a_im[2]);
    t1_re = SW'(a_re[0]) - SW'(a_re[2]);
    t1_im = SW'(a_im[0]) - SW'(a_im[2]);
    t2_re = SW'(a_re[1]) + SW'(a_re[3]);
    t2_im = SW'(a_im[1]) + SW'(a_im[3]);
    t3_re = SW'(a_re[1]) - SW'(a_re[3]);
    t3_im = SW'(a_im[1]) - SW'(a_im[3]);
    // t1 - j*t3 and t1 + j*t3
    mj_re = t1_re + t3_im;
    mj_im = t1_im - t3_re;
    pj_re = t1_re - t3_im;
    pj_im = t1_im + t3_re;

    y_re[0] = t0_re + t2_re;
    y_im[0] = t0_im + t2_im;
    y_re[2] = t0_re - t2_re;
    y_im[2] = t0_im - t2_im;
    y_re[1] = inverse ? pj_re : mj_re;
    y_im[1] = inverse ? pj_im : mj_im;
    y_re[3] = inverse ? mj_re : pj_re;
    y_im[3] = inverse ? mj_im : pj_im;
  end

endmodule

// File: rtl/fft16_radix4_stream.sv
// Streaming 16-point radix-4 FFT/IFFT: load 16 samples, two butterfly passes on
// one shared radix-4 unit, then stream 16 bins in natural order with backpressure.
module fft16_radix4_stream
  import fft_pkg::*;
#(
  parameter int DW         = 16,
  parameter int TW_W       = 16,
  parameter int SCALE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_inverse,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [3:0]           out_index,
  output logic                 out_last,
  output logic                 busy
);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cpx_t;

  function automatic logic signed [DW-1:0] to_dw(input logic signed [63:0] v);
    return DW'(sat_w(v, DW));
  endfunction

  function automatic logic signed [63:0] tw_scale(input logic signed [31:0] v);
    if (TW_W >= TW_REF_FRAC + 1) return 64'(v) <<< (TW_W - TW_REF_FRAC - 1);
    return 64'(v) >>> (TW_REF_FRAC + 1 - TW_W);
  endfunction

  // Exact bypass for 1, -j (+j when inverse), -1; table-driven multiply otherwise.
  function automatic cpx_t twiddle_mul(input cpx_t a, input logic [3:0] e, input logic inv);
    logic signed [63:0] ar, ai, wr, wi, pr, pi;
    tw_ref_t t;
    cpx_t r;
    ar = 64'(a.re);
    ai = 64'(a.im);
    case (e)
      4'd0: begin pr = ar; pi = ai; end
      4'd4: begin pr = inv ? -ai : ai; pi = inv ? ar : -ar; end
      4'd8: begin pr = -ar; pi = -ai; end
      default: begin
        t  = tw_lookup(e);
        wr = tw_scale(t.re);
        wi = inv ? -tw_scale(t.im) : tw_scale(t.im);
        pr = rnd_shr(ar * wr - ai * wi, TW_W - 1);
        pi = rnd_shr(ar * wi + ai * wr, TW_W - 1);
      end
    endcase
    r.re = to_dw(pr);
    r.im = to_dw(pi);
    return r;
  endfunction

  function automatic logic signed [DW-1:0] post_stage(input logic signed [DW+1:0] s);
    logic signed [63:0] v;
    v = 64'(s);
    if (SCALE_MODE == 1) v = rnd_shr(v, 2);
    return to_dw(v);
  endfunction

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       inv_q;
  logic       take_in, out_load, out_done;

  logic signed [DW-1:0] x_re  [16];
  logic signed [DW-1:0] x_im  [16];
  logic signed [DW-1:0] b1_re [16];
  logic signed [DW-1:0] b1_im [16];
  logic signed [DW-1:0] ob_re [16];
  logic signed [DW-1:0] ob_im [16];

  cpx_t                 b1_sel [4];
  cpx_t                 tw_out [4];
  logic signed [DW-1:0] bf_a_re [4];
  logic signed [DW-1:0] bf_a_im [4];
  logic signed [DW+1:0] bf_y_re [4];
  logic signed [DW+1:0] bf_y_im [4];
  logic signed [DW-1:0] st_re   [4];
  logic signed [DW-1:0] st_im   [4];

  assign busy = !(state == LOAD && cnt == 4'd0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = (state == LOAD);
    take_in  = 1'b0;
    out_load = 1'b0;
    out_done = 1'b0;
    unique case (state)
      LOAD: begin
        if (in_valid) begin
          take_in = 1'b1;
          if (cnt == 4'd15) begin
            state_nx = STG1;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      STG1: begin
        if (cnt == 4'd3) begin
          state_nx = STG2;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      STG2: begin
        if (cnt == 4'd3) begin
          state_nx = OUT;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      OUT: begin
        // cnt tracks the bin currently presented; first cycle in OUT only fills the register
        if (!out_valid) begin
          out_load = 1'b1;
        end else if (out_ready) begin
          if (cnt == 4'd15) begin
            out_done = 1'b1;
            state_nx = LOAD;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx   = cnt + 4'd1;
            out_load = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      cnt       <= 4'd0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= 4'd0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take_in && cnt == 4'd0) inv_q <= in_inverse;
      if (out_load) begin
        out_valid <= 1'b1;
        out_index <= cnt_nx;
        out_last  <= (cnt_nx == 4'd15);
        out_re    <= ob_re[cnt_nx];
        out_im    <= ob_im[cnt_nx];
      end else if (out_done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Butterfly operand select: x[n+4p] in STG1, twiddled B1[4n+k] in STG2
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      b1_sel[p].re = b1_re[{2'(p), cnt[1:0]}];
      b1_sel[p].im = b1_im[{2'(p), cnt[1:0]}];
      tw_out[p]    = twiddle_mul(b1_sel[p], 4'(p * int'(cnt[1:0])), inv_q);
      if (state == STG2) begin
        bf_a_re[p] = tw_out[p].re;
        bf_a_im[p] = tw_out[p].im;
      end else begin
        bf_a_re[p] = x_re[{2'(p), cnt[1:0]}];
        bf_a_im[p] = x_im[{2'(p), cnt[1:0]}];
      end
    end
  end

  radix4_bfly #(.DW(DW)) u_bfly (
    .a_re    (bf_a_re),
    .a_im    (bf_a_im),
    .inverse (inv_q),
    .y_re    (bf_y_re),
    .y_im    (bf_y_im)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      st_re[k] = post_stage(bf_y_re[k]);
      st_im[k] = post_stage(bf_y_im[k]);
    end
  end

  // Stage results: STG1 n=cnt -> B1[4n+k]; STG2 k=cnt -> OB[k+4m]
  always_ff @(posedge clk) begin
    if (take_in) begin
      x_re[cnt] <= in_re;
      x_im[cnt] <= in_im;
    end
    if (state == STG1) begin
      for (int k = 0; k < 4; k++) begin
        b1_re[{cnt[1:0], 2'(k)}] <= st_re[k];
        b1_im[{cnt[1:0], 2'(k)}] <= st_im[k];
      end
    end
    if (state == STG2) begin
      for (int m = 0; m < 4; m++) begin
        ob_re[{2'(m), cnt[1:0]}] <= st_re[m];
        ob_im[{2'(m), cnt[1:0]}] <= st_im[m];
      end
    end
  end

endmodule

// File: tb/tb_fft16_radix4_stream.sv
// Bench for fft16_radix4_stream: two instances (no scaling / per-stage scaling)
// share the stimulus; outputs are compared against a floating-point DFT model.
module tb_fft16_radix4_stream;

  localparam int  DW  = 16;
  localparam real TOL = 3.0;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset, in_valid, in_inverse, out_ready;
  logic signed [DW-1:0] in_re, in_im;

  logic in_ready0, out_valid0, out_last0, busy0;
  logic in_ready1, out_valid1, out_last1, busy1;
  logic [3:0] out_index0, out_index1;
  logic signed [DW-1:0] out_re0, out_im0, out_re1, out_im1;

  int  errors = 0;
  int  checks = 0;
  real exp_re0 [16];
  real exp_im0 [16];
  real exp_re1 [16];
  real exp_im1 [16];
  int  got_re0 [16];
  int  got_im0 [16];
  int  got_re1 [16];
  int  got_im1 [16];
  int  exp_idx = 16;
  int  bins_got = 0;
  int  vr [16];
  int  vi [16];

  always #5 clk = ~clk;

  fft16_radix4_stream #(.DW(DW), .TW_W(16), .SCALE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
    .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0),
    .out_index(out_index0), .out_last(out_last0), .busy(busy0)
  );

  fft16_radix4_stream #(.DW(DW), .TW_W(16), .SCALE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
    .out_valid(out_valid1), .out_ready(out_ready), .out_re(out_re1), .out_im(out_im1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_near(input string name, input int act, input real req);
    real d;
    checks++;
    d = act - req;
    if (d < 0.0) d = -d;
    if (d > TOL) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0.2f +/- %0.1f", name, act, req, TOL);
    end
  endtask

  function automatic real clamp_dw(input real v);
    if (v > 32767.0) return 32767.0;
    if (v < -32768.0) return -32768.0;
    return v;
  endfunction

  // Direct DFT: X[k] = sum x[n] * exp(-/+ j*2*pi*n*k/16)
  task automatic build_model(input int xr [16], input int xi [16], input bit inv);
    real acc_r, acc_i, th, sg;
    sg = inv ? 1.0 : -1.0;
    for (int k = 0; k < 16; k++) begin
      acc_r = 0.0;
      acc_i = 0.0;
      for (int n = 0; n < 16; n++) begin
        th = 2.0 * PI * real'(n * k) / 16.0;
        acc_r += real'(xr[n]) * $cos(th) - real'(xi[n]) * sg * $sin(th);
        acc_i += real'(xi[n]) * $cos(th) + real'(xr[n]) * sg * $sin(th);
      end
      exp_re0[k] = clamp_dw(acc_r);
      exp_im0[k] = clamp_dw(acc_i);
      exp_re1[k] = acc_r / 16.0;
      exp_im1[k] = acc_i / 16.0;
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid0 === 1'b1) begin
      if (exp_idx > 15) begin
        checks++;
        errors++;
        $display("FAIL extra_bin: got out_valid=1 index=%0d, expected no bin", out_index0);
      end else begin
        chk("out_index", int'(out_index0), exp_idx);
        chk("out_last", int'(out_last0), int'(exp_idx == 15));
        chk("in_ready_in_out", int'(in_ready0), 0);
        chk_near($sformatf("bin%0d_re_m0", exp_idx), int'(out_re0), exp_re0[exp_idx]);
        chk_near($sformatf("bin%0d_im_m0", exp_idx), int'(out_im0), exp_im0[exp_idx]);
        chk("m1_valid", int'(out_valid1), 1);
        chk("m1_index", int'(out_index1), exp_idx);
        chk_near($sformatf("bin%0d_re_m1", exp_idx), int'(out_re1), exp_re1[exp_idx]);
        chk_near($sformatf("bin%0d_im_m1", exp_idx), int'(out_im1), exp_im1[exp_idx]);
        if (out_ready === 1'b1) begin
          got_re0[exp_idx] = int'(out_re0);
          got_im0[exp_idx] = int'(out_im0);
          got_re1[exp_idx] = int'(out_re1);
          got_im1[exp_idx] = int'(out_im1);
          exp_idx++;
          bins_got++;
        end
      end
    end
  end

  task automatic run_frame(input int xr [16], input int xi [16], input bit inv, input bit bp);
    int lat;
    int tmo;
    build_model(xr, xi, inv);
    exp_idx   = 0;
    bins_got  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid   = 1'b1;
      in_re      = DW'(xr[i]);
      in_im      = DW'(xi[i]);
      in_inverse = (i == 0) ? inv : !inv;
      chk("in_ready_load", int'(in_ready0), 1);
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    in_re      = '0;
    in_im      = '0;
    in_inverse = 1'b0;
    if (bp) out_ready = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) chk("busy_processing", int'(busy0), 1);
      if (out_valid0 === 1'b1) break;
    end
    chk("latency", lat, 9);
    tmo = 0;
    while (bins_got < 16 && tmo < 400) begin
      if (bp) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      tmo++;
    end
    out_ready = 1'b1;
    chk("bins_received", bins_got, 16);
    chk("out_valid_after", int'(out_valid0), 0);
    chk("in_ready_after", int'(in_ready0), 1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_inverse = 1'b0;
    in_re      = '0;
    in_im      = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_last", int'(out_last0), 0);
    chk("rst_out_index", int'(out_index0), 0);
    chk("rst_out_re", int'(out_re0), 0);
    chk("rst_out_im", int'(out_im0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_m1_valid", int'(out_valid1), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // impulse
    vr = '{default: 0};
    vi = '{default: 0};
    vr[0] = 1000;
    run_frame(vr, vi, 1'b0, 1'b0);
    chk("impulse_re5", got_re0[5], 1000);
    chk("impulse_im5", got_im0[5], 0);
    chk("impulse_re15", got_re0[15], 1000);
    chk("impulse_m1_re7", got_re1[7], 63);

    // DC
    vr = '{default: 100};
    vi = '{default: 0};
    run_frame(vr, vi, 1'b0, 1'b0);
    chk("dc_m0_x0", got_re0[0], 1600);
    chk("dc_m0_x3", got_re0[3], 0);
    chk("dc_m1_x0", got_re1[0], 100);

    // single tone at x[1], forward then inverse
    vr = '{default: 0};
    vi = '{default: 0};
    vr[1] = 1000;
    run_frame(vr, vi, 1'b0, 1'b0);
    chk("tone_fwd_re4", got_re0[4], 0);
    chk("tone_fwd_im4", got_im0[4], -1000);
    chk("tone_fwd_re2", got_re0[2], 707);
    chk("tone_fwd_im2", got_im0[2], -707);
    run_frame(vr, vi, 1'b1, 1'b0);
    chk("tone_inv_re4", got_re0[4], 0);
    chk("tone_inv_im4", got_im0[4], 1000);

    // mixed vector, inverse, random backpressure
    vr = '{300, -200, 150, 400, -350, 120, -80, 250, 90, -410, 330, -60, 200, -150, 70, -300};
    vi = '{-120, 60, 0, 210, -90, 45, -300, 15, 180, -75, 20, -240, 95, 130, -55, 10};
    run_frame(vr, vi, 1'b1, 1'b1);

    // full-scale DC saturates X[0]
    vr = '{default: 32767};
    vi = '{default: 0};
    run_frame(vr, vi, 1'b0, 1'b1);
    chk("sat_m0_x0", got_re0[0], 32767);
    chk("sat_m0_x8", got_re0[8], 0);
    chk("sat_m1_x0", got_re1[0], 32767);

    // abort a frame with reset after 7 samples
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_re    = 16'sd500;
      in_im    = 16'sd0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", int'(in_ready0), 1);
    chk("abort_out_valid", int'(out_valid0), 0);
    chk("abort_busy", int'(busy0), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vr = '{default: 0};
    vi = '{default: 0};
    vr[0] = 1000;
    run_frame(vr, vi, 1'b0, 1'b0);
    chk("after_abort_re9", got_re0[9], 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
